// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiplier that borrows the external ALU as its adder; optional Booth signed mode via SIGNED_MUL_EN.
// Latency: 32 RUN cycles after accepted start, then a one-cycle done pulse; start is ignored outside IDLE.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow
);

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic             last_iter;

  assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MUL_EN
  logic       q_m1;
  logic [1:0] booth_op;
  logic       booth_use;
  logic       unused_cout;

  assign booth_op    = {product_lo[0], q_m1};
  assign booth_use   = booth_op[1] ^ booth_op[0];
  assign unused_cout = alu_cout;
`else
  logic unused_overflow;

  assign unused_overflow = alu_overflow;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = ALU_NOP;
    case (state)
      RUN: begin
        busy     = 1'b1;
        alu_src1 = product_hi;
        alu_src2 = mcand;
`ifdef SIGNED_MUL_EN
        case (booth_op)
          2'b10:   alu_ctrl = ALU_SUB;
          2'b01:   alu_ctrl = ALU_ADD;
          default: alu_ctrl = ALU_NOP;
        endcase
`else
        alu_ctrl = ALU_ADD;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand      <= '0;
      count      <= '0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef SIGNED_MUL_EN
      q_m1       <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      mcand      <= multiplicand;
      count      <= '0;
      product_hi <= '0;
      product_lo <= multiplier;
`ifdef SIGNED_MUL_EN
      q_m1       <= 1'b0;
`endif
    end else if (state == RUN) begin
      count <= count + CNT_W'(1);
`ifdef SIGNED_MUL_EN
      // Overflow-corrected sign keeps the arithmetic shift exact when the add/sub wraps.
      if (booth_use)
        {product_hi, product_lo, q_m1} <= {alu_result[WIDTH-1] ^ alu_overflow, alu_result, product_lo};
      else
        {product_hi, product_lo, q_m1} <= {product_hi[WIDTH-1], product_hi, product_lo};
`else
      // Carry out lands in the top product bit so nothing is lost on the shift.
      if (product_lo[0])
        {product_hi, product_lo} <= {alu_cout, alu_result, product_lo[WIDTH-1:1]};
      else
        {product_hi, product_lo} <= {1'b0, product_hi, product_lo[WIDTH-1:1]};
`endif
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural 32-bit ALU attached to the ALU ports.
module tb_alu_mul_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic [W-1:0] alu_src1;
  logic [W-1:0] alu_src2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_overflow;

  int checks = 0;
  int errors = 0;
  int ctrl_bad = 0;

  alu_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  // Reference ALU: add / subtract with carry and signed overflow.
  always_comb begin
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0010: begin
        {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_overflow = (alu_src1[W-1] == alu_src2[W-1]) && (alu_result[W-1] != alu_src1[W-1]);
      end
      4'b0110: begin
        {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_overflow = (alu_src1[W-1] != alu_src2[W-1]) && (alu_result[W-1] != alu_src1[W-1]);
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Walks from RUN cycle 1 until done; optionally re-pulses start (7 x 7) at RUN cycle inj+1.
  task automatic wait_done(input int inj, output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (busy && alu_ctrl != 4'b0010) ctrl_bad++;
        if (n == inj) begin
          multiplicand = 7;
          multiplier   = 7;
          start        = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic mul_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input int inj);
    int busy_cyc;
    bit seen;
    issue(a, b);
    check({tag, "_busy_first"}, {63'd0, busy}, 64'd1);
    wait_done(inj, busy_cyc, seen);
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
    check({tag, "_product"}, {product_hi, product_lo}, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    check({tag, "_product_hold"}, {product_hi, product_lo}, exp);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_product", {product_hi, product_lo}, 64'd0);
    check("rst_alu_src", {alu_src1, alu_src2}, 64'd0);
    check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_alu", {28'd0, alu_ctrl, alu_src1}, 64'd0);

    mul_case("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, -1);
`ifdef SIGNED_MUL_EN
    mul_case("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1);
`else
    mul_case("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    check("run_ctrl_add", 64'(ctrl_bad), 64'd0);
`endif
    mul_case("m0x1234", 32'd0, 32'h0000_1234, 64'd0, -1);
    mul_case("mshift", 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, -1);
    mul_case("ignored_start", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 9);
    check("idle_after_done", {alu_src1, alu_src2}, 64'd0);

    // Asynchronous reset in RUN cycle 15.
    issue(32'd3, 32'd5);
    repeat (14) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("mid_rst_product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mul_case("m2x9", 32'd2, 32'd9, 64'h0000_0000_0000_0012, -1);

`ifdef SIGNED_MUL_EN
    mul_case("s_m3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
    mul_case("s_min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Sequential 32x32 to 64-bit multiplier controller that sits directly in front of the 32-bit ALU. It reuses that ALU as its only adder.
- Each iteration it drives alu_src1/alu_src2/alu_ctrl into the ALU.
- In the same cycle it consumes the ALU's result/cout/overflow to form the next partial product.
- The core issues 32 shift-add iterations per multiply and reports the product with a done pulse.

Parameters:
WIDTH, 32, operand width; must equal ALU width; product is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
multiplicand  input  WIDTH  operand A; captured on accepted start
multiplier  input  WIDTH  operand B; captured on accepted start
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the product is valid
product_hi  output  WIDTH  upper half of the product
product_lo  output  WIDTH  lower half of the product
alu_src1  output  WIDTH  to ALU src1
alu_src2  output  WIDTH  to ALU src2
alu_ctrl  output  4  to ALU ALU_control
alu_result  input  WIDTH  from ALU result
alu_cout  input  1  from ALU cout
alu_overflow  input  1  from ALU overflow; used only with SIGNED_MUL_EN

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst clears all state immediately, including mid-operation.
- Reset values: state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, count=0, mcand register=0.
- States:
  - IDLE: start=1 loads mcand<=multiplicand, product_hi<=0, product_lo<=multiplier, count<=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: one iteration per cycle. count increments. After the iteration with count==WIDTH-1, goes to DONE.
  - DONE: done=1 for exactly this cycle, then unconditionally returns to IDLE. start in DONE is ignored.
- Busy and ignored starts: busy=1 only in RUN. start while busy or in DONE is ignored; operands are not re-sampled.
- Latency: start accepted at edge 0; 32 RUN cycles; done high during the cycle after edge 32. The product is stable from that cycle until the next accepted start.
- ALU drive (combinational from state):
  - RUN: alu_src1=product_hi, alu_src2=mcand, alu_ctrl=4'b0010 (add).
  - IDLE/DONE: alu_src1=0, alu_src2=0, alu_ctrl=4'b0000.
  - The ALU path is combinational; the result is consumed in the same cycle. No ALU pipeline stage is allowed.
- Unsigned iteration (default):
  - If product_lo[0]=1: {product_hi,product_lo} <= {alu_cout, alu_result, product_lo[WIDTH-1:1]}.
  - Else: {product_hi,product_lo} <= {1'b0, product_hi, product_lo[WIDTH-1:1]}.
- Width rule: no bit of the product is lost; the carry out of the ALU becomes product_hi[WIDTH-1] after the shift.
- Operand edge cases: multiplier=0 or multiplicand=0 yields 0 after the full 32 cycles. There is no early termination.

Optional Feature:
SIGNED_MUL_EN:
- Defined: operands are two's complement; radix-2 Booth.
  - An extra bit q_m1 is cleared on start.
  - Per RUN cycle, on the pair {product_lo[0], q_m1}:
    - 10: alu_ctrl=4'b0110 (sub).
    - 01: alu_ctrl=4'b0010 (add).
    - 00/11: no ALU use; alu_ctrl=4'b0000, and the add/sub path is bypassed.
  - The new top bit is alu_result[WIDTH-1]^alu_overflow, the true sign, for the add/sub case, or product_hi[WIDTH-1] otherwise.
  - {product_hi,product_lo,q_m1} is arithmetic-shifted right by 1.
- Undefined: unsigned behaviour only; alu_overflow is left unconnected internally.
- Timing is identical in both builds.

Test Plan:
- Reset, then start with 3 x 5 -> busy for 32 cycles; done pulse on cycle 33; product_hi=0x00000000, product_lo=0x0000000F.
- 0xFFFFFFFF x 0xFFFFFFFF unsigned -> product_hi=0xFFFFFFFE, product_lo=0x00000001; checks the alu_cout path.
- start pulsed again at RUN cycle 10 with operands 7 x 7 -> ignored; the original 3 x 5 result of 0xF completes on schedule.
- rst asserted at RUN cycle 15 -> busy, done and product go to 0 immediately. A new start of 2 x 9 after release yields 0x12.
- In IDLE, alu_ctrl=0000 and alu_src1=alu_src2=0; in RUN, alu_ctrl=0010 every cycle (unsigned build).
- With SIGNED_MUL_EN:
  - -3 x 5 -> 0xFFFFFFFF_FFFFFFF1.
  - 0x80000000 x 0x80000000 -> 0x40000000_00000000; exercises the overflow-corrected sign.
